// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU accesses to block RAM or the IO page, inserts RAM wait
// states and returns a one-cycle mio_ready. Define MIO_TIMER_EN to build in the interval timer.
module mio_bus_ctrl #(
    parameter int unsigned RAM_LAT = 2,
    parameter logic [23:0] IO_BASE = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_mem_w,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_data2bus,
    output logic [31:0] cpu_data4bus,
    output logic        mio_ready,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    input  logic [31:0] ram_dout,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic        int_out
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [5:0] IDX_LED  = 6'd0;
    localparam logic [5:0] IDX_SW   = 6'd1;
    localparam logic [5:0] IDX_CNT  = 6'd2;
    localparam logic [5:0] IDX_CMP  = 6'd3;
    localparam logic [5:0] IDX_CTRL = 6'd4;

    state_t      state_reg;
    logic [2:0]  wait_cnt_reg;
    logic        mio_ready_reg;
    logic        ram_we_reg;
    logic [31:0] rdata_reg;
    logic [15:0] led_reg;
    logic [15:0] sw_meta_reg;
    logic [15:0] sw_sync_reg;

    logic        is_io;
    logic [5:0]  io_idx;
    logic        io_wr;
    logic [31:0] io_rdata;
    logic        unused_addr_lsb;

    assign ram_addr        = cpu_addr[13:2];
    assign ram_din         = cpu_data2bus;
    assign is_io           = (cpu_addr[31:8] == IO_BASE);
    assign io_idx          = cpu_addr[7:2];
    assign io_wr           = (state_reg == IDLE) && cpu_req && is_io && cpu_mem_w;
    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign cpu_data4bus = rdata_reg;
    assign mio_ready    = mio_ready_reg;
    assign ram_we       = ram_we_reg;
    assign led_out      = led_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= sw_in;
            sw_sync_reg <= sw_meta_reg;
        end
    end

`ifdef MIO_TIMER_EN
    logic [31:0] cnt_reg;
    logic [31:0] cmp_reg;
    logic        en_reg;
    logic        pend_reg;
    logic        match;

    assign match   = en_reg && (cnt_reg == cmp_reg);
    assign int_out = pend_reg;

    // CPU write to CNT beats both the increment and the wrap on match; a match beats a pending clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg  <= '0;
            cmp_reg  <= '0;
            en_reg   <= 1'b0;
            pend_reg <= 1'b0;
        end else begin
            if (io_wr && io_idx == IDX_CNT)
                cnt_reg <= cpu_data2bus;
            else if (match)
                cnt_reg <= '0;
            else if (en_reg)
                cnt_reg <= cnt_reg + 32'd1;

            if (io_wr && io_idx == IDX_CMP)
                cmp_reg <= cpu_data2bus;

            if (io_wr && io_idx == IDX_CTRL)
                en_reg <= cpu_data2bus[0];

            if (match)
                pend_reg <= 1'b1;
            else if (io_wr && io_idx == IDX_CTRL && cpu_data2bus[1])
                pend_reg <= 1'b0;
        end
    end
`else
    assign int_out = 1'b0;
`endif

    always_comb begin
        io_rdata = '0;
        case (io_idx)
            IDX_LED:  io_rdata = {16'b0, led_reg};
            IDX_SW:   io_rdata = {16'b0, sw_sync_reg};
`ifdef MIO_TIMER_EN
            IDX_CNT:  io_rdata = cnt_reg;
            IDX_CMP:  io_rdata = cmp_reg;
            IDX_CTRL: io_rdata = {30'b0, pend_reg, en_reg};
`endif
            default:  io_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            mio_ready_reg <= 1'b0;
            ram_we_reg    <= 1'b0;
            rdata_reg     <= '0;
            led_reg       <= '0;
        end else begin
            mio_ready_reg <= 1'b0;
            ram_we_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cpu_req) begin
                        if (is_io) begin
                            if (cpu_mem_w) begin
                                if (io_idx == IDX_LED)
                                    led_reg <= cpu_data2bus[15:0];
                            end else begin
                                rdata_reg <= io_rdata;
                            end
                            mio_ready_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else if (cpu_mem_w) begin
                            ram_we_reg    <= 1'b1;
                            mio_ready_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            wait_cnt_reg <= 3'(RAM_LAT - 1);
                            state_reg    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg == 3'd0) begin
                        rdata_reg     <= ram_dout;
                        mio_ready_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 3'd1;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mio_bus_ctrl.md
# mio_bus_ctrl

Memory/IO bus controller between the multi-cycle CPU's memory port and the block RAM. It decodes each CPU access to RAM or a small memory-mapped IO page, inserts RAM wait states, and returns a one-cycle `mio_ready` handshake. The IO page holds LED and switch registers and an optional interval timer whose interrupt drives the CPU's `INTsignal`.

## Interface
- `RAM_LAT`, 2: RAM read latency in cycles from address to valid `ram_dout`, 1..7.
- `IO_BASE`, 24'hFFFFFF: `cpu_addr[31:8]` value selecting the IO page.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cpu_req`  in  1  access request, held high until `mio_ready` is seen.
- `cpu_mem_w`  in  1  1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr`  in  32  byte address; `[1:0]` ignored.
- `cpu_data2bus`  in  32  write data.
- `cpu_data4bus`  out  32  registered read data.
- `mio_ready`  out  1  one-cycle completion pulse.
- `ram_addr`  out  12  `cpu_addr[13:2]`, combinational.
- `ram_din`  out  32  `cpu_data2bus`, combinational.
- `ram_we`  out  1  registered write strobe.
- `ram_dout`  in  32  RAM read data.
- `sw_in`  in  16  asynchronous switch inputs.
- `led_out`  out  16  LED register.
- `int_out`  out  1  timer interrupt request to the CPU.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE transitions:
  - `cpu_req`=0: stay in IDLE.
  - RAM read: go to WAIT and load the wait counter with RAM_LAT-1.
  - RAM write: go to DONE with `ram_we`=1 in that cycle.
  - IO read or write: perform the register access at this edge, then go to DONE.
- WAIT: decrement the counter each cycle. When it reaches 0, latch `ram_dout` into `cpu_data4bus` and go to DONE.
- DONE: `mio_ready`=1 for exactly this one cycle, then go to IDLE unconditionally. The CPU drops or changes `cpu_req` by the next edge. `cpu_req` is sampled again only in IDLE.
- Address decode: IO when `cpu_addr[31:8]`==IO_BASE, otherwise RAM.
- IO register map, by offset `cpu_addr[7:2]`:
  - 0x00 LED: RW, bits [15:0]; reads return them zero-extended.
  - 0x04 SW: RO; value is `sw_in` after a 2-flop synchronizer, zero-extended. Writes are ignored.
  - 0x08 CNT, 0x0C CMP, 0x10 CTRL: timer registers, see Configuration.
  - Other offsets: read 0, writes ignored.
- An IO write leaves `cpu_data4bus` unchanged. A RAM write also leaves it unchanged.
- Reset, including mid-access: state goes to IDLE immediately. `mio_ready`, `ram_we`, `cpu_data4bus`, `led_out`, CNT, CMP, CTRL and `int_out` all go to 0, as do the synchronizer flops. An access in flight is dropped and the CPU must reissue it.

## Timing
- The request is sampled at edge E, with the FSM in IDLE.
- RAM read: data is captured at edge E+RAM_LAT. `mio_ready` is high from E+RAM_LAT to E+RAM_LAT+1. Total occupancy is RAM_LAT+1 cycles.
- RAM write: `ram_we` and `mio_ready` are both high from E to E+1. The RAM captures the data at E+1.
- IO access: the register updates or read data is latched at E. `mio_ready` is high from E to E+1.
- Back-to-back: a new request can be sampled no earlier than E_ready+1. The minimum spacing is 2 cycles for IO and writes.
- `ram_addr` and `ram_din` follow the CPU combinationally. The CPU holds them stable while `cpu_req` is high.

## Configuration
- Macro `MIO_TIMER_EN`.
- When defined, the IO timer is compiled in:
  - CNT (32 b, RW): increments every cycle while `CTRL[0]` (enable) is 1.
  - CMP (32 b, RW): the match value.
  - CTRL: `[0]` enable (RW); `[1]` pending (RO, write 1 to clear).
  - Match: when CNT==CMP with enable set, CNT goes to 0 on the next edge and pending is set.
  - `int_out` = pending.
  - A CPU write to CNT in the same cycle as an increment: the write wins.
  - A pending clear in the same cycle as a match: the set wins.
- When undefined, CNT, CMP and CTRL read 0, writes to them are ignored, and `int_out` is tied to 0.

## Test plan
- Reset, then RAM write to 0x0000_0010 with 0xDEADBEEF at RAM_LAT=2 -> `ram_we`=1 and `ram_addr`=4 for one cycle, `mio_ready` 1 cycle after the request. A following read of that address -> `cpu_data4bus`=0xDEADBEEF, `mio_ready` 2 cycles after the request.
- Write 0xFFFF_FF00 with 0x0001_A5A5 -> `led_out`=0xA5A5. Read it back -> 0x0000_A5A5. Read 0xFFFF_FF04 with `sw_in`=0x1234 held for 3 cycles -> 0x0000_1234. Read offset 0x3C -> 0.
- Assert `reset` while in WAIT -> `mio_ready` never pulses, state is IDLE, `led_out`=0. The reissued read completes normally.
- `MIO_TIMER_EN`: CMP=3, CTRL=1 -> CNT counts 0,1,2,3,0 and `int_out` rises in the cycle after CNT=3. Write CTRL=0x3 -> `int_out` falls. A clear issued exactly at the next match -> `int_out` stays 1.
- Without `MIO_TIMER_EN`: the same writes -> reads of 0x08, 0x0C and 0x10 return 0 and `int_out` stays 0.
- `cpu_req` held high continuously across two reads -> exactly one `mio_ready` per access, and the second access starts at the edge after DONE.
